// File: rtl/lcd_text_feeder_if.sv
// lcd_text_feeder_if: producer stream, LCD controller handshake and status
// signals of the text feeder, bundled for a single port connection.
interface lcd_text_feeder_if #(
  parameter int DEPTH = 16
);
  localparam int LEVEL_W = $clog2(DEPTH) + 1;

  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               clear;
  logic               lcd_busy;
  logic               lcd_e;
  logic [7:0]         lcd_data;
  logic               lcd_rs;
  logic [LEVEL_W-1:0] level;
  logic               err;

  // Feeder side: consumes the byte stream, drives the controller strobe.
  modport slave (
    input  in_valid, in_data, clear, lcd_busy,
    output in_ready, lcd_e, lcd_data, lcd_rs, level, err
  );

  // Environment side: producer plus LCD controller.
  modport master (
    output in_valid, in_data, clear, lcd_busy,
    input  in_ready, lcd_e, lcd_data, lcd_rs, level, err
  );
endinterface

// File: rtl/lcd_text_feeder.sv
// lcd_text_feeder: buffers a byte stream in a FIFO and hands each byte to the
// LCD controller as a one-cycle strobe while the controller is idle. Tracks the
// cursor and inserts DDRAM address commands on line wrap.
// Optional feature macro: LCD_FEEDER_CTRL_CHARS_EN -- when defined, 0x0A
// (newline) and 0x0C (form feed) become controller commands instead of text.
module lcd_text_feeder #(
  parameter int DEPTH       = 16,
  parameter int COLS        = 16,
  parameter int ROWS        = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  lcd_text_feeder_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int COL_W = $clog2(COLS + 1);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT_ACK, WAIT_DONE} state_t;

  // FIFO storage and pointers (one extra bit separates full from empty)
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  logic [7:0]  head;
  logic        is_nl, is_ff;

  // Sequencer and cursor state
  state_t           state, state_next;
  logic [CNT_W-1:0] ack_cnt, ack_cnt_next;
  logic [COL_W-1:0] col, col_next;
  logic [ROW_W-1:0] row, row_next, row_inc;
  logic             cmd_pend, cmd_pend_next;
  logic [7:0]       cmd_byte, cmd_byte_next;
  logic             e_q, e_next;
  logic             rs_q, rs_next;
  logic             err_q, err_next;
  logic [7:0]       data_q, data_next;

  // Set-DDRAM-address command for the first column of row r (8-bit math).
  function automatic logic [7:0] addr_cmd(input logic [ROW_W-1:0] r);
    logic [7:0] addr;
    addr = 8'(r) * 8'h40;
    return 8'h80 | {1'b0, addr[6:0]};
  endfunction

  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bus.in_ready = !full && !bus.clear;
  assign push         = bus.in_valid && bus.in_ready;
  assign bus.level    = wr_ptr - rd_ptr;
  assign head         = mem[rd_ptr[AW-1:0]];
  assign row_inc      = (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);

`ifdef LCD_FEEDER_CTRL_CHARS_EN
  assign is_nl = (head == 8'h0A);
  assign is_ff = (head == 8'h0C);
`else
  assign is_nl = 1'b0;
  assign is_ff = 1'b0;
`endif

  assign bus.lcd_e    = e_q;
  assign bus.lcd_data = data_q;
  assign bus.lcd_rs   = rs_q;
  assign bus.err      = err_q;

  // Byte storage write port.
  // NOTE: the storage array has no reset; a location is only read after it
  // was written, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.in_data;
  end

  // FIFO pointers; clear empties the buffer and wins over a same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Sequencer: pick next byte/command, strobe it, then follow the busy handshake.
  // NOTE: every variable gets a default at the top so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_next    = state;
    ack_cnt_next  = ack_cnt;
    col_next      = col;
    row_next      = row;
    cmd_pend_next = cmd_pend;
    cmd_byte_next = cmd_byte;
    e_next        = 1'b0;
    data_next     = data_q;
    rs_next       = rs_q;
    err_next      = err_q;
    pop           = 1'b0;

    case (state)
      IDLE: begin
        if (!bus.lcd_busy && !bus.clear) begin
          if (cmd_pend) begin
            // A pending address command goes out before any queued text.
            data_next     = cmd_byte;
            rs_next       = 1'b0;
            cmd_pend_next = 1'b0;
            e_next        = 1'b1;
            state_next    = STROBE;
          end else if (!empty) begin
            pop        = 1'b1;
            e_next     = 1'b1;
            state_next = STROBE;
            if (is_nl) begin
              row_next  = row_inc;
              col_next  = '0;
              data_next = addr_cmd(row_inc);
              rs_next   = 1'b0;
            end else if (is_ff) begin
              row_next  = '0;
              col_next  = '0;
              data_next = 8'h01;
              rs_next   = 1'b0;
            end else begin
              data_next = head;
              rs_next   = 1'b1;
              if (col == COL_W'(COLS - 1)) begin
                // Row is full: move to the next row and queue its address.
                col_next      = '0;
                row_next      = row_inc;
                cmd_pend_next = 1'b1;
                cmd_byte_next = addr_cmd(row_inc);
              end else begin
                col_next = col + COL_W'(1);
              end
            end
          end
        end
      end
      STROBE: begin
        ack_cnt_next = '0;
        state_next   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.lcd_busy) begin
          state_next = WAIT_DONE;
        end else if (ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          ack_cnt_next = ack_cnt + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.lcd_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // clear resets the cursor but lets an in-flight transfer finish.
    if (bus.clear) begin
      cmd_pend_next = 1'b0;
      row_next      = '0;
      col_next      = '0;
    end
  end

  // Sequencer, cursor and output registers.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ack_cnt  <= '0;
      col      <= '0;
      row      <= '0;
      cmd_pend <= 1'b0;
      cmd_byte <= 8'h00;
      e_q      <= 1'b0;
      data_q   <= 8'h00;
      rs_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_next;
      ack_cnt  <= ack_cnt_next;
      col      <= col_next;
      row      <= row_next;
      cmd_pend <= cmd_pend_next;
      cmd_byte <= cmd_byte_next;
      e_q      <= e_next;
      data_q   <= data_next;
      rs_q     <= rs_next;
      err_q    <= err_next;
    end
  end
endmodule
